// File: rtl/ins_route_if.sv
// Bundle handshake between an instruction source and ins_route, plus the routed output side.
// The master drives instruction bundles and out_ready; the slave (ins_route) answers.
interface ins_route_if #(
  parameter int LANES  = 4,
  parameter int DES_W  = 4,
  parameter int SRC1_W = 4,
  parameter int SRC2_W = 4,
  parameter int IMM_W  = 4,
  parameter int BR_W   = 3,
  parameter int OP_W   = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES-1:0]        in_vld;
  logic [LANES-1:0]        in_mem;
  logic [LANES*DES_W-1:0]  in_des;
  logic [LANES*SRC1_W-1:0] in_s1;
  logic [LANES*SRC2_W-1:0] in_s2;
  logic [LANES*OP_W-1:0]   in_op;
  logic [LANES*BR_W-1:0]   in_br;
  logic [LANES*IMM_W-1:0]  in_imm;

  logic                    out_valid;
  logic                    out_ready;
  logic [LANES-1:0]        out_vld;
  logic [LANES*DES_W-1:0]  out_des;
  logic [LANES*SRC1_W-1:0] out_s1;
  logic [LANES*SRC2_W-1:0] out_s2;
  logic [LANES*OP_W-1:0]   out_op;
  logic [LANES*BR_W-1:0]   out_br;
  logic [LANES*IMM_W-1:0]  out_imm;
  logic                    out_split;
  logic [15:0]             split_cnt;

  modport master (
    output in_valid, in_vld, in_mem, in_des, in_s1, in_s2, in_op, in_br, in_imm, out_ready,
    input  in_ready, out_valid, out_vld, out_des, out_s1, out_s2, out_op, out_br, out_imm,
           out_split, split_cnt
  );

  modport slave (
    input  in_valid, in_vld, in_mem, in_des, in_s1, in_s2, in_op, in_br, in_imm, out_ready,
    output in_ready, out_valid, out_vld, out_des, out_s1, out_s2, out_op, out_br, out_imm,
           out_split, split_cnt
  );
endinterface

// File: rtl/ins_route.sv
// Issue router: sends at most one load/store per cycle to the last lane, splitting bundles
// that carry several memory ops into consecutive in-order issue cycles.
//   state | meaning
//   IDLE  | no residual, ready for a new input bundle
//   SPLIT | residual lanes held, issuing them before accepting more input
module ins_route #(
  parameter int LANES  = 4,
  parameter int DES_W  = 4,
  parameter int SRC1_W = 4,
  parameter int SRC2_W = 4,
  parameter int IMM_W  = 4,
  parameter int BR_W   = 3,
  parameter int OP_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  ins_route_if.slave  bus
);
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);

  typedef enum logic {IDLE, SPLIT} state_t;
  state_t state;

  logic [LANES-1:0]        res_vld, res_mem;
  logic [LANES*DES_W-1:0]  res_des;
  logic [LANES*SRC1_W-1:0] res_s1;
  logic [LANES*SRC2_W-1:0] res_s2;
  logic [LANES*OP_W-1:0]   res_op;
  logic [LANES*BR_W-1:0]   res_br;
  logic [LANES*IMM_W-1:0]  res_imm;

  logic [LANES-1:0]        w_vld, w_mem, issue, left, r_vld;
  logic [LANES*DES_W-1:0]  w_des, r_des;
  logic [LANES*SRC1_W-1:0] w_s1, r_s1;
  logic [LANES*SRC2_W-1:0] w_s2, r_s2;
  logic [LANES*OP_W-1:0]   w_op, r_op;
  logic [LANES*BR_W-1:0]   w_br, r_br;
  logic [LANES*IMM_W-1:0]  w_imm, r_imm;
  logic                    idle, can_go, adv, seen, stop, mem_iss;
  logic [IW-1:0]           slot, dst;

  logic                    out_valid_q, out_split_q;
  logic [LANES-1:0]        out_vld_q;
  logic [LANES*DES_W-1:0]  out_des_q;
  logic [LANES*SRC1_W-1:0] out_s1_q;
  logic [LANES*SRC2_W-1:0] out_s2_q;
  logic [LANES*OP_W-1:0]   out_op_q;
  logic [LANES*BR_W-1:0]   out_br_q;
  logic [LANES*IMM_W-1:0]  out_imm_q;
  logic [15:0]             split_cnt_q;

  always_comb begin
    idle   = (state == IDLE);
    can_go = !out_valid_q || bus.out_ready;
    adv    = can_go && (idle ? bus.in_valid : 1'b1);
    w_vld  = idle ? bus.in_vld : res_vld;
    w_mem  = idle ? bus.in_mem : res_mem;
    w_des  = idle ? bus.in_des : res_des;
    w_s1   = idle ? bus.in_s1  : res_s1;
    w_s2   = idle ? bus.in_s2  : res_s2;
    w_op   = idle ? bus.in_op  : res_op;
    w_br   = idle ? bus.in_br  : res_br;
    w_imm  = idle ? bus.in_imm : res_imm;

    // Issue every valid lane older than the second valid memory lane.
    issue = '0; seen = 1'b0; stop = 1'b0; mem_iss = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (w_vld[i] && w_mem[i]) begin
        stop = stop | seen;
        seen = 1'b1;
      end
      if (w_vld[i] && !stop) begin
        issue[i] = 1'b1;
        if (w_mem[i]) mem_iss = 1'b1;
      end
    end
    left = w_vld & ~issue;

    r_vld = '0; r_des = '0; r_s1 = '0; r_s2 = '0; r_op = '0; r_br = '0; r_imm = '0;
    slot = '0; dst = '0;
    if (!mem_iss) begin
      r_vld = issue; r_des = w_des; r_s1 = w_s1; r_s2 = w_s2;
      r_op  = w_op;  r_br  = w_br;  r_imm = w_imm;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (issue[i]) begin
          if (w_mem[i]) dst = LAST;
          else begin
            dst  = slot;
            slot = slot + 1'b1;
          end
          r_vld[dst] = 1'b1;
          r_des[dst*DES_W +: DES_W]  = w_des[i*DES_W +: DES_W];
          r_s1[dst*SRC1_W +: SRC1_W] = w_s1[i*SRC1_W +: SRC1_W];
          r_s2[dst*SRC2_W +: SRC2_W] = w_s2[i*SRC2_W +: SRC2_W];
          r_op[dst*OP_W +: OP_W]     = w_op[i*OP_W +: OP_W];
          r_br[dst*BR_W +: BR_W]     = w_br[i*BR_W +: BR_W];
          r_imm[dst*IMM_W +: IMM_W]  = w_imm[i*IMM_W +: IMM_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      res_vld <= '0; res_mem <= '0; res_des <= '0; res_s1 <= '0;
      res_s2  <= '0; res_op  <= '0; res_br  <= '0; res_imm <= '0;
      out_valid_q <= 1'b0; out_split_q <= 1'b0; out_vld_q <= '0;
      out_des_q <= '0; out_s1_q <= '0; out_s2_q <= '0; out_op_q <= '0;
      out_br_q  <= '0; out_imm_q <= '0; split_cnt_q <= '0;
    end else if (adv) begin
      state   <= (|left) ? SPLIT : IDLE;
      res_vld <= left;  res_mem <= w_mem; res_des <= w_des; res_s1 <= w_s1;
      res_s2  <= w_s2;  res_op  <= w_op;  res_br  <= w_br;  res_imm <= w_imm;
      out_valid_q <= |issue;
      // An all-invalid bundle issues nothing and leaves the output register untouched.
      if (|issue) begin
        out_vld_q <= r_vld; out_des_q <= r_des; out_s1_q <= r_s1; out_s2_q <= r_s2;
        out_op_q  <= r_op;  out_br_q  <= r_br;  out_imm_q <= r_imm;
        out_split_q <= !idle || (|left);
        if (!idle && split_cnt_q != 16'hFFFF) split_cnt_q <= split_cnt_q + 16'd1;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = idle && can_go;
  assign bus.out_valid = out_valid_q;
  assign bus.out_vld   = out_vld_q;
  assign bus.out_des   = out_des_q;
  assign bus.out_s1    = out_s1_q;
  assign bus.out_s2    = out_s2_q;
  assign bus.out_op    = out_op_q;
  assign bus.out_br    = out_br_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_split = out_split_q;
  assign bus.split_cnt = split_cnt_q;
endmodule
